// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
// One column is driven low at a time; rows are read back through a
// two-flop synchronizer. A debounced press produces a one-cycle key_valid
// strobe plus the row/col indices, and key_held stays high until the
// release of that same key has been debounced.
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       key_valid,
  output logic       key_held
);

  // Counters carry one spare bit so they can saturate instead of wrapping.
  localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT) + 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX  = '1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = '1;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]        row_meta;
  logic [3:0]        rs;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [1:0]        col_idx;
  logic [1:0]        cand_row;
  logic [1:0]        enc_row;

  logic press_seen;
  logic rs_cand;
  logic scan_last;
  logic deb_last;
  logic latch_cand;
  logic accept;
  logic advance_col;

  // Two-flop synchronizer; idle rows read as all ones (pulled up).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row_in;
      rs       <= row_meta;
    end
  end

  // Lowest-numbered low row wins when several rows are pulled down.
  always_comb begin
    enc_row = 2'd0;
    if (!rs[0]) begin
      enc_row = 2'd0;
    end else if (!rs[1]) begin
      enc_row = 2'd1;
    end else if (!rs[2]) begin
      enc_row = 2'd2;
    end else if (!rs[3]) begin
      enc_row = 2'd3;
    end
  end

  // Shared condition decode used by both the FSM and the datapath.
  always_comb begin
    press_seen = (rs != 4'hF);
    rs_cand    = rs[cand_row];
    scan_last  = (scan_cnt == SCAN_LAST);
    deb_last   = (deb_cnt == DEB_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      SCAN: begin
        if (scan_last && press_seen) begin
          state_next = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (rs_cand) begin
          state_next = SCAN;
        end else if (deb_last) begin
          state_next = HELD;
        end
      end
      HELD: begin
        if (rs_cand) begin
          state_next = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (!rs_cand) begin
          state_next = HELD;
        end else if (deb_last) begin
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // FSM outputs: column drive, held flag and datapath control strobes.
  always_comb begin
    col_out          = 4'hF;
    col_out[col_idx] = 1'b0;
    key_held         = (state == HELD) || (state == DEB_RELEASE);
    latch_cand       = 1'b0;
    accept           = 1'b0;
    advance_col      = 1'b0;
    case (state)
      SCAN: begin
        if (scan_last) begin
          latch_cand  = press_seen;
          advance_col = !press_seen;
        end
      end
      DEB_PRESS: begin
        if (rs_cand) begin
          advance_col = 1'b1;
        end else if (deb_last) begin
          accept = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (rs_cand && deb_last) begin
          advance_col = 1'b1;
        end
      end
      default: begin
        latch_cand  = 1'b0;
        accept      = 1'b0;
        advance_col = 1'b0;
      end
    endcase
  end

  // Column dwell counter: runs only while scanning, cleared at each column change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if ((state == SCAN) && !scan_last) begin
      if (scan_cnt != SCAN_MAX) begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end else begin
      scan_cnt <= '0;
    end
  end

  // Debounce counter: counts consecutive stable cycles of the candidate row bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
    end else begin
      case (state)
        DEB_PRESS: begin
          if (!rs_cand && !deb_last) begin
            if (deb_cnt != DEB_MAX) begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        DEB_RELEASE: begin
          if (rs_cand && !deb_last) begin
            if (deb_cnt != DEB_MAX) begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        default: deb_cnt <= '0;
      endcase
    end
  end

  // Active column index; stays put while a key is being debounced or held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= 2'd0;
    end else if (advance_col) begin
      col_idx <= col_idx + 2'd1;
    end
  end

  // Candidate row captured when the scan first sees a low row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_row <= 2'd0;
    end else if (latch_cand) begin
      cand_row <= enc_row;
    end
  end

  // Accepted key indices and the one-cycle valid strobe for the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= 2'd0;
      col       <= 2'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        row <= cand_row;
        col <= col_idx;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks for keypad_scanner with short scan and
// debounce periods. A keypad model pulls row r low whenever a pressed key
// (r,c) sits on the currently driven column c.
`timescale 1ns/1ps

module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int PRESS_BOUND  = 4 * SCAN_DIV + DEBOUNCE_CNT + 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [1:0] row;
  logic [1:0] col;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;

  int errors     = 0;
  int checks     = 0;
  int pulse_cnt  = 0;
  int onehot_bad = 0;

  typedef struct {
    int r;
    int c;
    int hold;
    int exp_row;
    int exp_col;
    int exp_code;
  } press_vec_t;

  press_vec_t vecs[4];

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key shorts its row to its column line.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) begin
          row_in[r] = 1'b0;
        end
      end
    end
  end

  // Background monitor: counts key_valid cycles and column-drive violations.
  always @(negedge clk) begin
    if (key_valid) pulse_cnt++;
    if ($countones(~col_out) != 1) onehot_bad++;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down);
    keys[r*4+c] = down;
  endtask

  task automatic waitKeyValid(input int bound, output int seen, output int lat);
    seen = 0;
    lat  = 0;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (key_valid) begin
        seen = 1;
        lat  = k;
        break;
      end
    end
  endtask

  task automatic waitHeldLow(input int bound, output int seen);
    seen = 0;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (!key_held) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic waitColumnStart(input int c);
    logic [3:0] target;
    logic [3:0] prev;
    int         found;
    target    = 4'hF;
    target[c] = 1'b0;
    found     = 0;
    for (int k = 0; k < 40; k++) begin
      prev = col_out;
      tick();
      if (prev != target && col_out == target) begin
        found = 1;
        break;
      end
    end
    checkOutput("wait_column_start", found, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_col_out"}, col_out, 4'b1110);
    checkOutput({tag, "_row"}, row, 0);
    checkOutput({tag, "_col"}, col, 0);
    checkOutput({tag, "_key_valid"}, key_valid, 0);
    checkOutput({tag, "_key_held"}, key_held, 0);
  endtask

  initial begin
    int         seen;
    int         lat;
    int         base;
    logic [3:0] exp_col_out;

    vecs[0] = '{2, 1, 40, 2, 1, 6};
    vecs[1] = '{0, 0, 10, 0, 0, 0};
    vecs[2] = '{3, 3,  5, 3, 3, 15};
    vecs[3] = '{1, 2, 12, 1, 2, 9};

    // Reset values.
    rst_n = 1'b0;
    keys  = '0;
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Idle scan: each column driven for SCAN_DIV cycles in order 0,1,2,3.
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_col_out = 4'hF;
      exp_col_out[(k / 4) % 4] = 1'b0;
      checkOutput("idle_col_out", col_out, exp_col_out);
    end
    checkOutput("idle_no_valid", pulse_cnt, 0);

    // Single key presses from the table.
    for (int i = 0; i < 4; i++) begin
      base = pulse_cnt;
      applyStimulus(vecs[i].r, vecs[i].c, 1'b1);
      waitKeyValid(PRESS_BOUND, seen, lat);
      checkOutput("press_seen", seen, 1);
      checkOutput("press_row", row, vecs[i].exp_row);
      checkOutput("press_col", col, vecs[i].exp_col);
      checkOutput("press_code", {col, row}, vecs[i].exp_code);
      checkOutput("press_held_on_valid", key_held, 1);
      repeat (vecs[i].hold) tick();
      checkOutput("press_held_while_down", key_held, 1);
      applyStimulus(vecs[i].r, vecs[i].c, 1'b0);
      repeat (8) tick();
      checkOutput("release_held_8clk", key_held, 1);
      waitHeldLow(8, seen);
      checkOutput("release_held_drop", seen, 1);
      repeat (4) tick();
      checkOutput("press_pulse_count", pulse_cnt - base, 1);
    end

    // Bouncing key (0,3): toggles every 3 clocks for 30 clocks, then stable.
    base = pulse_cnt;
    for (int s = 0; s < 10; s++) begin
      applyStimulus(0, 3, (s % 2) == 0);
      repeat (3) tick();
    end
    checkOutput("bounce_no_valid", pulse_cnt - base, 0);
    applyStimulus(0, 3, 1'b1);
    waitKeyValid(40, seen, lat);
    checkOutput("bounce_seen", seen, 1);
    checkOutput("bounce_after_stable", lat >= DEBOUNCE_CNT, 1);
    checkOutput("bounce_row", row, 0);
    checkOutput("bounce_col", col, 3);
    applyStimulus(0, 3, 1'b0);
    waitHeldLow(20, seen);
    checkOutput("bounce_release", seen, 1);
    repeat (4) tick();
    checkOutput("bounce_pulse_count", pulse_cnt - base, 1);

    // Glitch on (2,2) lasting 5 clocks, aligned to the start of column 2.
    base = pulse_cnt;
    waitColumnStart(2);
    applyStimulus(2, 2, 1'b1);
    repeat (5) tick();
    checkOutput("glitch_col_held", col_out, 4'b1011);
    applyStimulus(2, 2, 1'b0);
    repeat (3) tick();
    checkOutput("glitch_next_col", col_out, 4'b0111);
    repeat (10) tick();
    checkOutput("glitch_no_valid", pulse_cnt - base, 0);
    checkOutput("glitch_row_kept", row, 0);
    checkOutput("glitch_col_kept", col, 3);

    // Rows 1 and 3 together on column 2; only row 1 release ends the hold.
    base = pulse_cnt;
    applyStimulus(1, 2, 1'b1);
    applyStimulus(3, 2, 1'b1);
    waitKeyValid(PRESS_BOUND, seen, lat);
    checkOutput("multi_seen", seen, 1);
    checkOutput("multi_row", row, 1);
    checkOutput("multi_col", col, 2);
    applyStimulus(3, 2, 1'b0);
    repeat (20) tick();
    checkOutput("multi_held_after_row3", key_held, 1);
    applyStimulus(1, 2, 1'b0);
    waitHeldLow(20, seen);
    checkOutput("multi_release", seen, 1);
    repeat (4) tick();
    checkOutput("multi_pulse_count", pulse_cnt - base, 1);

    // Reset asserted while debouncing a press of (2,3).
    waitColumnStart(3);
    applyStimulus(2, 3, 1'b1);
    repeat (5) tick();
    checkOutput("rst1_in_debounce", col_out, 4'b0111);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst1");
    applyStimulus(2, 3, 1'b0);
    tick();
    tick();
    base  = pulse_cnt;
    rst_n = 1'b1;
    tick();
    checkOutput("rst1_restart_col0", col_out, 4'b1110);
    repeat (3) tick();
    checkOutput("rst1_next_col1", col_out, 4'b1101);
    repeat (26) tick();
    checkOutput("rst1_no_valid", pulse_cnt - base, 0);

    // Reset asserted while key (3,1) is held.
    applyStimulus(3, 1, 1'b1);
    waitKeyValid(PRESS_BOUND, seen, lat);
    checkOutput("rst2_seen", seen, 1);
    checkOutput("rst2_row", row, 3);
    checkOutput("rst2_col", col, 1);
    repeat (3) tick();
    checkOutput("rst2_held", key_held, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst2");
    applyStimulus(3, 1, 1'b0);
    tick();
    tick();
    base  = pulse_cnt;
    rst_n = 1'b1;
    tick();
    checkOutput("rst2_restart_col0", col_out, 4'b1110);
    repeat (3) tick();
    checkOutput("rst2_next_col1", col_out, 4'b1101);
    repeat (26) tick();
    checkOutput("rst2_no_valid", pulse_cnt - base, 0);

    checkOutput("col_out_onehot", onehot_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
